universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 119 +++++++++++
 tb/tb_universal_shift_reg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   WIDTH-bit universal shift register: hold, shift right, shift left and
//   parallel load, with a shift counter that wraps every WIDTH shifts and
//   flags each completed word with a one-cycle done pulse.
//
//   Ports
//     clk     rising-edge clock
//     reset   asynchronous reset, active low
//     en      operation enable (0 holds everything, done drops)
//     mode    00 hold, 01 shift right, 10 shift left, 11 parallel load
//     din     parallel load data
//     sin_r   serial in, enters the MSB on a right shift
//     sin_l   serial in, enters the LSB on a left shift
//     dout    registered parallel output
//     sout_r  right-shift serial out (dout[0], combinational)
//     sout_l  left-shift serial out (dout[WIDTH-1], combinational)
//     cnt     shifts since last load/reset, range 0..WIDTH-1
//     done    registered one-cycle pulse after WIDTH shifts
// -----------------------------------------------------------------------------

// Per-bit storage cell. Each bit only needs its own load bit and its two
// neighbours, so the register is built as an array of identical cells.
module usr_bit_cell (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       ld_d,     // parallel load bit
   input  logic       from_hi,  // value arriving on a right shift
   input  logic       from_lo,  // value arriving on a left shift
   output logic       q
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 1'b0;
      end else if (en) begin
         unique case (mode)
            2'b01:   q <= from_hi;
            2'b10:   q <= from_lo;
            2'b11:   q <= ld_d;
            default: q <= q;
         endcase
      end
   end
endmodule

module universal_shift_reg #(
   parameter int WIDTH = 4,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] dout,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    cnt,
   output logic             done
);
   localparam logic [1:0]    M_SHR  = 2'b01;
   localparam logic [1:0]    M_SHL  = 2'b10;
   localparam logic [1:0]    M_LOAD = 2'b11;
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

   // Neighbour vectors: bit i takes nbr_hi[i] on a right shift and
   // nbr_lo[i] on a left shift. The serial inputs sit at the ends, so they
   // only ever reach the register when the matching shift mode is selected.
   logic [WIDTH-1:0] nbr_hi;
   logic [WIDTH-1:0] nbr_lo;

   assign nbr_hi = {sin_r, dout[WIDTH-1:1]};
   assign nbr_lo = {dout[WIDTH-2:0], sin_l};

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      usr_bit_cell u_cell (
         .clk     (clk),
         .reset   (reset),
         .en      (en),
         .mode    (mode),
         .ld_d    (din[i]),
         .from_hi (nbr_hi[i]),
         .from_lo (nbr_lo[i]),
         .q       (dout[i])
      );
   end

   assign sout_r = dout[0];
   assign sout_l = dout[WIDTH-1];

   // Shift counter and done pulse. Direction is irrelevant to the count;
   // a load restarts the word; done is high only in the cycle right after
   // the shift that completes a word, and drops on anything else.
   logic shift_go;
   assign shift_go = en && (mode == M_SHR || mode == M_SHL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (en && mode == M_LOAD) begin
            cnt <= '0;
         end else if (shift_go) begin
            if (cnt == LAST) begin
               cnt  <= '0;
               done <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH=4. Inputs are driven 1ns
// after the rising edge and outputs sampled 1ns after the next rising edge.
module tb_universal_shift_reg;
   localparam int WIDTH = 4;
   localparam int CW    = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] din;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] dout;
   logic             sout_r;
   logic             sout_l;
   logic [CW-1:0]    cnt;
   logic             done;

   int n_run  = 0;
   int n_fail = 0;

   universal_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .mode   (mode),
      .din    (din),
      .sin_r  (sin_r),
      .sin_l  (sin_l),
      .dout   (dout),
      .sout_r (sout_r),
      .sout_l (sout_l),
      .cnt    (cnt),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic state(input string tag, input logic [3:0] d, input int c, input logic dn);
      chk({tag, ".dout"}, 32'(dout), 32'(d));
      chk({tag, ".cnt"},  32'(cnt),  32'(c));
      chk({tag, ".done"}, 32'(done), 32'(dn));
   endtask

   task automatic load(input logic [3:0] v);
      en = 1'b1; mode = 2'b11; din = v;
      tick();
   endtask

   // expected dout after each right shift, sout_r before it, and cnt after
   logic [3:0] pr_d [4] = '{4'b1100, 4'b1110, 4'b1111, 4'b1111};
   logic       pr_s [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic [3:0] pl_d [4] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
   logic       pl_s [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic       si_in[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic [3:0] si_d [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
   logic [1:0] mx_m [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [3:0] mx_d [4] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};

   initial begin
      reset = 1'b0; en = 1'b0; mode = 2'b00; din = '0; sin_r = 1'b0; sin_l = 1'b0;
      #2;
      state("rst", 4'b0000, 0, 1'b0);
      #1 reset = 1'b1;
      tick();

      // PIPO
      load(4'b1001); state("pipo1", 4'b1001, 0, 1'b0);
      load(4'b1010); state("pipo2", 4'b1010, 0, 1'b0);
      load(4'b1111); state("pipo3", 4'b1111, 0, 1'b0);

      // PISO right, sin_r=1; sin_l toggled to show it is ignored
      load(4'b1001);
      for (int i = 0; i < 4; i++) begin
         en = 1'b1; mode = 2'b01; sin_r = 1'b1; sin_l = i[0];
         chk($sformatf("pisor.sout%0d", i), 32'(sout_r), 32'(pr_s[i]));
         tick();
         state($sformatf("pisor%0d", i), pr_d[i], (i + 1) % 4, i == 3);
      end
      mode = 2'b00; tick();
      state("pisor.hold", 4'b1111, 0, 1'b0);

      // PISO left, sin_l=0
      load(4'b1010);
      for (int i = 0; i < 4; i++) begin
         en = 1'b1; mode = 2'b10; sin_l = 1'b0; sin_r = 1'b1;
         chk($sformatf("pisol.sout%0d", i), 32'(sout_l), 32'(pl_s[i]));
         tick();
         state($sformatf("pisol%0d", i), pl_d[i], (i + 1) % 4, i == 3);
      end

      // Load in the same cycle that done is high
      load(4'b0000);
      state("ld_on_done", 4'b0000, 0, 1'b0);

      // SIPO
      for (int i = 0; i < 4; i++) begin
         en = 1'b1; mode = 2'b01; sin_r = si_in[i];
         tick();
         state($sformatf("sipo%0d", i), si_d[i], (i + 1) % 4, i == 3);
      end
      mode = 2'b00; tick();
      state("sipo.hold", 4'b1101, 0, 1'b0);

      // Mixed directions count the same
      load(4'b0000);
      for (int i = 0; i < 4; i++) begin
         en = 1'b1; mode = mx_m[i]; sin_r = 1'b1; sin_l = 1'b1;
         tick();
         state($sformatf("mix%0d", i), mx_d[i], (i + 1) % 4, i == 3);
      end

      // Abort / hold
      load(4'b0000);
      en = 1'b1; mode = 2'b01; sin_r = 1'b1; tick();
      tick();
      state("abort.sh2", 4'b1100, 2, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mode = 2'(i + 1);
         tick();
         state($sformatf("abort.en0_%0d", i), 4'b1100, 2, 1'b0);
      end
      load(4'b0110); state("abort.ld", 4'b0110, 0, 1'b0);
      en = 1'b1; mode = 2'b00; tick();
      state("abort.after", 4'b0110, 0, 1'b0);

      // Async reset mid-sequence
      load(4'b1001);
      for (int i = 0; i < 3; i++) begin
         en = 1'b1; mode = 2'b01; sin_r = 1'b1; tick();
      end
      state("ar.pre", 4'b1111, 3, 1'b0);
      #2 reset = 1'b0;
      #1 state("ar.now", 4'b0000, 0, 1'b0);
      tick();
      state("ar.held", 4'b0000, 0, 1'b0);
      #2 reset = 1'b1;
      mode = 2'b00;
      tick();
      state("ar.rel", 4'b0000, 0, 1'b0);
      mode = 2'b01; sin_r = 1'b1; tick();
      state("ar.sh1", 4'b1000, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
